// File: rtl/md5_crack_pkg.sv
// Shared types and constants for the MD5 brute-force job controller.
package md5_crack_pkg;

  localparam int unsigned MAX_LEN  = 15;
  localparam int unsigned GUESS_W  = 128;
  localparam int unsigned DIGEST_W = 128;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  // LSB of character idx; character 0 sits in the top byte of the guess word.
  function automatic int unsigned byte_lsb(input int unsigned idx);
    return GUESS_W - 8 * (idx + 1);
  endfunction

endpackage

// File: rtl/md5_guess_odometer.sv
// Keyspace odometer: the last character of the guess increments fastest and a
// character at the high bound wraps to the low bound and carries left.
module md5_guess_odometer
  import md5_crack_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_advance,
  input  logic [3:0]         i_len,
  input  logic [7:0]         i_lo,
  input  logic [7:0]         i_hi,
  output logic [GUESS_W-1:0] o_guess,
  output logic               o_last
);

  logic [GUESS_W-1:0] r_guess;
  logic [GUESS_W-1:0] w_load_val;
  logic [GUESS_W-1:0] w_next;
  logic               w_last;
  logic               w_carry;

  // Load value, successor guess and "every active character at hi" flag.
  always_comb begin
    w_load_val = '0;
    w_next     = r_guess;
    w_last     = 1'b1;
    w_carry    = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (4'(i) < i_len) begin
        w_load_val[byte_lsb(i) +: 8] = i_lo;
        if (r_guess[byte_lsb(i) +: 8] != i_hi) begin
          w_last = 1'b0;
        end
      end
    end
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      if ((4'(i) < i_len) && w_carry) begin
        if (r_guess[byte_lsb(i) +: 8] == i_hi) begin
          w_next[byte_lsb(i) +: 8] = i_lo;
        end else begin
          w_next[byte_lsb(i) +: 8] = r_guess[byte_lsb(i) +: 8] + 8'd1;
          w_carry = 1'b0;
        end
      end
    end
  end

  // Guess register: load wins over advance.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_guess <= '0;
    end else if (i_load) begin
      r_guess <= w_load_val;
    end else if (i_advance) begin
      r_guess <= w_next;
    end
  end

  assign o_guess = r_guess;
  assign o_last  = w_last;

endmodule

// File: rtl/md5_crack_scheduler.sv
// Job controller for one MD5 pipeline: issues one guess per clock, tracks each
// guess through the fixed pipeline latency and reports the first digest match.
module md5_crack_scheduler
  import md5_crack_pkg::*;
#(
  parameter int unsigned PIPE_LATENCY = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [3:0]          i_cfg_len,
  input  logic [7:0]          i_cfg_lo,
  input  logic [7:0]          i_cfg_hi,
  input  logic [31:0]         i_cfg_count,
  input  logic [DIGEST_W-1:0] i_target,
  output logic [GUESS_W-1:0]  o_pipe_guess,
  output logic [3:0]          o_pipe_len,
  output logic                o_pipe_valid,
  input  logic [DIGEST_W-1:0] i_pipe_hash,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_found,
  output logic [GUESS_W-1:0]  o_found_guess,
  output logic [31:0]         o_issued
);

  localparam int unsigned CNT_W = $clog2(PIPE_LATENCY + 2);

  state_e              r_state;
  logic [3:0]          r_len;
  logic [7:0]          r_lo;
  logic [7:0]          r_hi;
  logic [31:0]         r_count;
  logic [DIGEST_W-1:0] r_target;
  logic [31:0]         r_issued;
  logic                r_found;
  logic [GUESS_W-1:0]  r_found_guess;
  logic                r_done;
  logic                r_busy;
  logic                r_pipe_valid;
  logic [CNT_W-1:0]    r_drain_cnt;

  logic [PIPE_LATENCY-1:0] r_tag_valid;
  logic [GUESS_W-1:0]      r_tag_guess [PIPE_LATENCY];
  logic                    r_hit;
  logic [GUESS_W-1:0]      r_hit_guess;

  logic               w_idle_or_done;
  logic               w_load;
  logic               w_bad_cfg;
  logic               w_last_issue;
  logic               w_advance;
  logic [3:0]         w_odo_len;
  logic [7:0]         w_odo_lo;
  logic [7:0]         w_odo_hi;
  logic [GUESS_W-1:0] w_guess;
  logic               w_odo_last;

  assign w_idle_or_done = (r_state == StIdle) || (r_state == StDone);
  assign w_load         = i_start && !i_abort && w_idle_or_done;
  assign w_bad_cfg      = (i_cfg_len == 4'd0) || (i_cfg_lo > i_cfg_hi);
  assign w_last_issue   = ((r_count != 32'd0) && (r_issued == r_count - 32'd1)) || w_odo_last;
  // Stop advancing on the final guess so pipe_guess keeps showing it.
  assign w_advance      = (r_state == StRun) && !i_abort && !r_hit && !w_last_issue;

  // The odometer sees the incoming config on the load cycle, latched config after.
  assign w_odo_len = w_load ? i_cfg_len : r_len;
  assign w_odo_lo  = w_load ? i_cfg_lo  : r_lo;
  assign w_odo_hi  = w_load ? i_cfg_hi  : r_hi;

  md5_guess_odometer u_odometer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_len     (w_odo_len),
    .i_lo      (w_odo_lo),
    .i_hi      (w_odo_hi),
    .o_guess   (w_guess),
    .o_last    (w_odo_last)
  );

  // Job FSM with registered status outputs; abort beats start and hits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_len         <= '0;
      r_lo          <= '0;
      r_hi          <= '0;
      r_count       <= '0;
      r_target      <= '0;
      r_issued      <= '0;
      r_found       <= 1'b0;
      r_found_guess <= '0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_pipe_valid  <= 1'b0;
      r_drain_cnt   <= '0;
    end else if (i_abort) begin
      r_state      <= StIdle;
      r_found      <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_pipe_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_len         <= i_cfg_len;
            r_lo          <= i_cfg_lo;
            r_hi          <= i_cfg_hi;
            r_count       <= i_cfg_count;
            r_target      <= i_target;
            r_issued      <= '0;
            r_found       <= 1'b0;
            r_found_guess <= '0;
            r_drain_cnt   <= '0;
            if (w_bad_cfg) begin
              r_state      <= StDone;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_pipe_valid <= 1'b0;
            end else begin
              r_state      <= StRun;
              r_done       <= 1'b0;
              r_busy       <= 1'b1;
              r_pipe_valid <= 1'b1;
            end
          end
        end
        StRun: begin
          if (r_issued != '1) begin
            r_issued <= r_issued + 32'd1;
          end
          if (r_hit) begin
            r_state       <= StDone;
            r_found       <= 1'b1;
            r_found_guess <= r_hit_guess;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_pipe_valid  <= 1'b0;
          end else if (w_last_issue) begin
            r_state      <= StDrain;
            r_pipe_valid <= 1'b0;
            r_drain_cnt  <= '0;
          end
        end
        StDrain: begin
          if (r_hit) begin
            r_state       <= StDone;
            r_found       <= 1'b1;
            r_found_guess <= r_hit_guess;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
          end else if (r_drain_cnt == CNT_W'(PIPE_LATENCY)) begin
            r_state <= StDone;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Tag valid shift and registered compare; flushed outside RUN/DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_abort || w_idle_or_done) begin
      r_tag_valid <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_tag_valid[0] <= r_pipe_valid;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
      end
      r_hit <= r_tag_valid[PIPE_LATENCY-1] && (i_pipe_hash == r_target);
    end
  end

  // Tag guess payload travels alongside the valid bits; qualified by them.
  always_ff @(posedge i_clk) begin
    r_tag_guess[0] <= w_guess;
    for (int i = 1; i < PIPE_LATENCY; i++) begin
      r_tag_guess[i] <= r_tag_guess[i-1];
    end
    r_hit_guess <= r_tag_guess[PIPE_LATENCY-1];
  end

  assign o_pipe_guess  = w_guess;
  assign o_pipe_len    = r_len;
  assign o_pipe_valid  = r_pipe_valid;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_found       = r_found;
  assign o_found_guess = r_found_guess;
  assign o_issued      = r_issued;

endmodule

// File: tb/tb_md5_crack_scheduler.sv
// Directed bench for md5_crack_scheduler with a behavioural MD5 pipeline model.
module tb_md5_crack_scheduler;

  localparam int PL = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic [3:0]   cfg_len;
  logic [7:0]   cfg_lo;
  logic [7:0]   cfg_hi;
  logic [31:0]  cfg_count;
  logic [127:0] target;
  logic [127:0] pipe_guess;
  logic [3:0]   pipe_len;
  logic         pipe_valid;
  logic [127:0] pipe_hash;
  logic         busy;
  logic         done;
  logic         found;
  logic [127:0] found_guess;
  logic [31:0]  issued;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [127:0] log_g [$];
  int           log_c [$];
  logic [127:0] hst [PL];

  always #5 clk = ~clk;

  md5_crack_scheduler #(.PIPE_LATENCY(PL)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_abort       (abort),
    .i_cfg_len     (cfg_len),
    .i_cfg_lo      (cfg_lo),
    .i_cfg_hi      (cfg_hi),
    .i_cfg_count   (cfg_count),
    .i_target      (target),
    .o_pipe_guess  (pipe_guess),
    .o_pipe_len    (pipe_len),
    .o_pipe_valid  (pipe_valid),
    .i_pipe_hash   (pipe_hash),
    .o_busy        (busy),
    .o_done        (done),
    .o_found       (found),
    .o_found_guess (found_guess),
    .o_issued      (issued)
  );

  // Single-block MD5 of the first n bytes of g (first byte in g[127:120]).
  function automatic logic [127:0] md5_digest(input logic [127:0] g, input logic [3:0] n);
    logic [7:0]  blk [64];
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f, t, k, x;
    int          sh [16];
    int          gi, s;
    real         sv;
    longint      kl;
    sh = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < 16; i++) if (i < int'(n)) blk[i] = g[127 - 8*i -: 8];
    blk[n]  = 8'h80;
    blk[56] = {1'b0, n, 3'b000};
    for (int j = 0; j < 16; j++) m[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); gi = i;                end
      else if (i < 32) begin f = (d & b) | (~d & c); gi = (5*i + 1) % 16;   end
      else if (i < 48) begin f = b ^ c ^ d;          gi = (3*i + 5) % 16;   end
      else             begin f = c ^ (b | ~d);       gi = (7*i) % 16;       end
      s  = sh[(i / 16) * 4 + (i % 4)];
      sv = $sin(real'(i + 1));
      if (sv < 0.0) sv = -sv;
      kl = longint'($floor(sv * 4294967296.0));
      k  = kl[31:0];
      x  = a + f + k + m[gi];
      t  = d; d = c; c = b;
      b  = b + ((x << s) | (x >> (32 - s)));
      a  = t;
    end
    return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
  endfunction

  // Left-align up to three characters into the guess layout.
  function automatic logic [127:0] mk(input logic [23:0] s, input int n);
    logic [127:0] r;
    r = '0;
    r[127:104] = s << (8 * (3 - n));
    return r;
  endfunction

  // Behavioural pipeline: digest appears PL clocks after the guess is sampled.
  always @(posedge clk) begin
    hst[0] <= pipe_valid ? md5_digest(pipe_guess, pipe_len) : '0;
    for (int i = 1; i < PL; i++) hst[i] <= hst[i-1];
  end
  assign pipe_hash = hst[PL-1];

  // Issue log: every guess the pipeline samples, with its clock index.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (pipe_valid) begin
      log_g.push_back(pipe_guess);
      log_c.push_back(cyc);
    end
  end

  task automatic start_job(input logic [3:0] len, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [31:0] cnt, input logic [127:0] tgt);
    @(negedge clk);
    log_g.delete();
    log_c.delete();
    cfg_len = len; cfg_lo = lo; cfg_hi = hi; cfg_count = cnt; target = tgt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles from the post-start negedge until done, plus drain-like cycles seen.
  task automatic wait_done(output int cycles, output int drain);
    cycles = 0;
    drain  = 0;
    while (!done && cycles < 60) begin
      if (busy && !pipe_valid) drain++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({pipe_valid, busy, done, found} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset.flags: got %b want 0000", {pipe_valid, busy, done, found});
    end
    n_vec++;
    if ({pipe_guess, found_guess, issued, pipe_len} !== '0) begin
      n_err++;
      $display("FAIL reset.data: got guess=%h fg=%h issued=%0d len=%0d want all 0",
               pipe_guess, found_guess, issued, pipe_len);
    end
  endtask

  task automatic test_single_hit;
    int c, dr;
    start_job(4'd1, 8'h61, 8'h63, 32'd0, md5_digest(mk("b", 1), 4'd1));
    wait_done(c, dr);
    n_vec++;
    if (c != 2 + PL + 1) begin
      n_err++; $display("FAIL single_hit.done_cycle: got %0d want %0d", c, 2 + PL + 1);
    end
    n_vec++;
    if (found !== 1'b1 || found_guess !== mk("b", 1)) begin
      n_err++; $display("FAIL single_hit.found: got %b %h want 1 %h", found, found_guess, mk("b", 1));
    end
    n_vec++;
    if (issued !== 32'd3 || log_g.size() != 3) begin
      n_err++; $display("FAIL single_hit.issued: got %0d/%0d want 3/3", issued, log_g.size());
    end else begin
      n_vec++;
      if (log_g[0] !== mk("a", 1) || log_g[1] !== mk("b", 1) || log_g[2] !== mk("c", 1)) begin
        n_err++; $display("FAIL single_hit.seq: got %h %h %h want a b c", log_g[0], log_g[1], log_g[2]);
      end
      n_vec++;
      if (log_c[1] != log_c[0] + 1 || log_c[2] != log_c[1] + 1) begin
        n_err++; $display("FAIL single_hit.consecutive: got cycles %0d %0d %0d want consecutive",
                          log_c[0], log_c[1], log_c[2]);
      end
    end
  endtask

  task automatic test_exhaust_nohit;
    int c, dr;
    start_job(4'd2, 8'h61, 8'h62, 32'd0, md5_digest(mk("zz", 2), 4'd2));
    wait_done(c, dr);
    n_vec++;
    if (dr != PL + 1 || c != 4 + PL + 1) begin
      n_err++; $display("FAIL exhaust.drain: got drain=%0d done@%0d want %0d/%0d", dr, c, PL + 1, 4 + PL + 1);
    end
    n_vec++;
    if (done !== 1'b1 || found !== 1'b0 || busy !== 1'b0 || issued !== 32'd4) begin
      n_err++; $display("FAIL exhaust.status: got done=%b found=%b busy=%b issued=%0d want 1 0 0 4",
                        done, found, busy, issued);
    end
    n_vec++;
    if (log_g.size() != 4) begin
      n_err++; $display("FAIL exhaust.count: got %0d want 4", log_g.size());
    end else if (log_g[0] !== mk("aa", 2) || log_g[1] !== mk("ab", 2) ||
                 log_g[2] !== mk("ba", 2) || log_g[3] !== mk("bb", 2)) begin
      n_err++; $display("FAIL exhaust.seq: got %h %h %h %h want aa ab ba bb",
                        log_g[0], log_g[1], log_g[2], log_g[3]);
    end
  endtask

  task automatic test_count_limit;
    int c, dr;
    logic [127:0] exp_g;
    start_job(4'd3, 8'h30, 8'h39, 32'd5, md5_digest(mk("999", 3), 4'd3));
    wait_done(c, dr);
    n_vec++;
    if (issued !== 32'd5 || found !== 1'b0 || done !== 1'b1 || c != 5 + PL + 1) begin
      n_err++; $display("FAIL count.status: got issued=%0d found=%b done=%b @%0d want 5 0 1 @%0d",
                        issued, found, done, c, 5 + PL + 1);
    end
    n_vec++;
    if (log_g.size() != 5) begin
      n_err++; $display("FAIL count.size: got %0d want 5", log_g.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp_g = mk({16'h3030, 8'h30 + 8'(i)}, 3);
        n_vec++;
        if (log_g[i] !== exp_g) begin
          n_err++; $display("FAIL count.guess%0d: got %h want %h", i, log_g[i], exp_g);
        end
      end
    end
  endtask

  task automatic test_last_guess_hit;
    int c, dr;
    start_job(4'd1, 8'h61, 8'h63, 32'd0, md5_digest(mk("c", 1), 4'd1));
    wait_done(c, dr);
    n_vec++;
    if (found !== 1'b1 || found_guess !== mk("c", 1) || c != 3 + PL + 1 || issued !== 32'd3) begin
      n_err++; $display("FAIL last_hit: got found=%b fg=%h @%0d issued=%0d want 1 %h @%0d 3",
                        found, found_guess, c, issued, mk("c", 1), 3 + PL + 1);
    end
  endtask

  task automatic test_abort;
    start_job(4'd1, 8'h61, 8'h63, 32'd0, md5_digest(mk("a", 1), 4'd1));
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if (pipe_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || issued !== 32'd1) begin
      n_err++; $display("FAIL abort.now: got valid=%b busy=%b done=%b issued=%0d want 0 0 0 1",
                        pipe_valid, busy, done, issued);
    end
    repeat (10) @(negedge clk);
    n_vec++;
    if (found !== 1'b0 || done !== 1'b0 || pipe_valid !== 1'b0 || issued !== 32'd1) begin
      n_err++; $display("FAIL abort.later: got found=%b done=%b valid=%b issued=%0d want 0 0 0 1",
                        found, done, pipe_valid, issued);
    end
  endtask

  task automatic test_bad_cfg;
    start_job(4'd0, 8'h61, 8'h63, 32'd0, md5_digest(mk("a", 1), 4'd1));
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || pipe_valid !== 1'b0 || issued !== 32'd0 || found !== 1'b0) begin
      n_err++; $display("FAIL bad_len: got done=%b busy=%b valid=%b issued=%0d found=%b want 1 0 0 0 0",
                        done, busy, pipe_valid, issued, found);
    end
    start_job(4'd2, 8'h7a, 8'h61, 32'd0, md5_digest(mk("a", 1), 4'd1));
    repeat (3) @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || issued !== 32'd0 || log_g.size() != 0) begin
      n_err++; $display("FAIL bad_range: got done=%b busy=%b issued=%0d issues=%0d want 1 0 0 0",
                        done, busy, issued, log_g.size());
    end
  endtask

  task automatic test_reset_mid_run;
    start_job(4'd3, 8'h30, 8'h39, 32'd0, md5_digest(mk("999", 3), 4'd3));
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1 || issued !== 32'd3) begin
      n_err++; $display("FAIL mid_run.running: got busy=%b issued=%0d want 1 3", busy, issued);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if ({pipe_valid, busy, done, found} !== 4'b0000 ||
        {pipe_guess, found_guess, issued, pipe_len} !== '0) begin
      n_err++; $display("FAIL mid_run.reset: got v=%b b=%b d=%b f=%b guess=%h issued=%0d want all 0",
                        pipe_valid, busy, done, found, pipe_guess, issued);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_len = '0; cfg_lo = '0; cfg_hi = '0; cfg_count = '0; target = '0;
    test_reset();
    test_single_hit();
    test_exhaust_nohit();
    test_count_limit();
    test_last_guess_hit();
    test_abort();
    test_bad_cfg();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
